vram_rd_arbiter: RTL and testbench

//  Shares one AXI3/4 read port (address + data channels) between two burst requesters.

---
 rtl/vram_rd_arbiter.sv | 148 ++++++++++++++
 tb/tb_vram_rd_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_rd_arbiter.sv
// Two-master burst arbiter sharing one AXI read port (AR + R channels); one burst in flight at a time.
// Define VRAM_RD_ARB_FIXPRI_EN for fixed priority (port0 wins ties); default is round-robin.
module vram_rd_arbiter #(
    parameter int AW   = 32,
    parameter int DW   = 64,
    parameter int LENW = 8
) (
    input  logic            ACLK,
    input  logic            ARST,
    input  logic [AW-1:0]   M0_ARADDR,
    input  logic [LENW-1:0] M0_ARLEN,
    input  logic            M0_ARVALID,
    output logic            M0_ARREADY,
    output logic [DW-1:0]   M0_RDATA,
    output logic            M0_RLAST,
    output logic            M0_RVALID,
    input  logic            M0_RREADY,
    input  logic [AW-1:0]   M1_ARADDR,
    input  logic [LENW-1:0] M1_ARLEN,
    input  logic            M1_ARVALID,
    output logic            M1_ARREADY,
    output logic [DW-1:0]   M1_RDATA,
    output logic            M1_RLAST,
    output logic            M1_RVALID,
    input  logic            M1_RREADY,
    output logic [AW-1:0]   S_ARADDR,
    output logic [LENW-1:0] S_ARLEN,
    output logic            S_ARVALID,
    input  logic            S_ARREADY,
    input  logic [DW-1:0]   S_RDATA,
    input  logic            S_RLAST,
    input  logic            S_RVALID,
    output logic            S_RREADY,
    output logic            BUSY,
    output logic            LEN_ERR
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            gnt_q, gnt_d;
    logic [LENW-1:0] len_q, len_d;
    logic [LENW:0]   cnt_q, cnt_d;
    logic            len_err_q, len_err_d;
    logic            pick;
    logic            g_arvalid, g_rready;
    logic            in_addr, in_data;
    logic            ar_hs, r_hs;

`ifdef VRAM_RD_ARB_FIXPRI_EN
    assign pick = ~M0_ARVALID;
`else
    logic last_q, last_d;
    // On a tie the port that did not own the previous burst wins.
    assign pick = (M0_ARVALID && M1_ARVALID) ? ~last_q : M1_ARVALID;
`endif

    assign in_addr   = (state_q == ST_ADDR);
    assign in_data   = (state_q == ST_DATA);
    assign g_arvalid = gnt_q ? M1_ARVALID : M0_ARVALID;
    assign g_rready  = gnt_q ? M1_RREADY  : M0_RREADY;
    assign ar_hs     = in_addr && g_arvalid && S_ARREADY;
    assign r_hs      = in_data && S_RVALID && g_rready;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        len_err_d = len_err_q;
`ifndef VRAM_RD_ARB_FIXPRI_EN
        last_d    = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (M0_ARVALID || M1_ARVALID) begin
                    gnt_d   = pick;
                    len_d   = pick ? M1_ARLEN : M0_ARLEN;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ar_hs) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_hs) begin
                    cnt_d = cnt_q + 1'b1;
                    if (S_RLAST) begin
                        // Compare the pre-increment count: a correct burst ends with cnt == ARLEN.
                        if (cnt_q != {1'b0, len_q}) len_err_d = 1'b1;
`ifndef VRAM_RD_ARB_FIXPRI_EN
                        last_d = gnt_q;
`endif
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 1'b0;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
`ifndef VRAM_RD_ARB_FIXPRI_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
`ifndef VRAM_RD_ARB_FIXPRI_EN
            last_q    <= last_d;
`endif
        end
    end

    always_ff @(posedge ACLK) begin
        len_q <= len_d;
    end

    assign S_ARADDR   = gnt_q ? M1_ARADDR : M0_ARADDR;
    assign S_ARLEN    = gnt_q ? M1_ARLEN  : M0_ARLEN;
    assign S_ARVALID  = in_addr && g_arvalid;
    assign M0_ARREADY = in_addr && !gnt_q && S_ARREADY;
    assign M1_ARREADY = in_addr &&  gnt_q && S_ARREADY;

    assign S_RREADY   = in_data && g_rready;
    assign M0_RDATA   = S_RDATA;
    assign M1_RDATA   = S_RDATA;
    assign M0_RVALID  = in_data && !gnt_q && S_RVALID;
    assign M1_RVALID  = in_data &&  gnt_q && S_RVALID;
    assign M0_RLAST   = in_data && !gnt_q && S_RLAST;
    assign M1_RLAST   = in_data &&  gnt_q && S_RLAST;

    assign BUSY       = (state_q != ST_IDLE);
    assign LEN_ERR    = len_err_q;

endmodule

// File: tb/tb_vram_rd_arbiter.sv
// Directed bench for vram_rd_arbiter: acts as both read masters and as the AXI slave.
module tb_vram_rd_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int LENW = 8;

    logic ACLK, ARST;
    logic [AW-1:0] M0_ARADDR, M1_ARADDR, S_ARADDR;
    logic [LENW-1:0] M0_ARLEN, M1_ARLEN, S_ARLEN;
    logic M0_ARVALID, M0_ARREADY, M0_RLAST, M0_RVALID, M0_RREADY;
    logic M1_ARVALID, M1_ARREADY, M1_RLAST, M1_RVALID, M1_RREADY;
    logic [DW-1:0] M0_RDATA, M1_RDATA, S_RDATA;
    logic S_ARVALID, S_ARREADY, S_RLAST, S_RVALID, S_RREADY, BUSY, LEN_ERR;

    int n_chk = 0;
    int n_fail = 0;

    vram_rd_arbiter #(.AW(AW), .DW(DW), .LENW(LENW)) dut (
        .ACLK(ACLK), .ARST(ARST),
        .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
        .M0_RDATA(M0_RDATA), .M0_RLAST(M0_RLAST), .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
        .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
        .M1_RDATA(M1_RDATA), .M1_RLAST(M1_RLAST), .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
        .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA), .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .BUSY(BUSY), .LEN_ERR(LEN_ERR)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000ns, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    // Acts as slave for one burst: accepts the address, then streams last_at beats of base+i.
    // Reports the granted port, the accepted address, beats delivered and protocol/routing errors.
    task automatic serve(input int last_at, input logic [63:0] base, input bit toggle, input bit keep,
                         output int gnt, output logic [AW-1:0] addr, output int beats, output int bad);
        int t, cyc, i;
        logic grv, grr, ngrv, grl;
        logic [DW-1:0] grd;
        gnt = -1; beats = 0; bad = 0; addr = '0;
        S_ARREADY = 1'b1;
        #1;
        t = 0;
        while (!S_ARVALID && t < 20) begin tick(); #1; t++; end
        gnt  = M1_ARREADY ? 1 : (M0_ARREADY ? 0 : -1);
        addr = S_ARADDR;
        tick();
        S_ARREADY = 1'b0;
        if (!keep) begin
            if (gnt == 1) M1_ARVALID = 1'b0; else M0_ARVALID = 1'b0;
        end
        i = 0; cyc = 0;
        while (i < last_at && cyc < 600) begin
            S_RVALID = 1'b1;
            S_RDATA  = base + 64'(i);
            S_RLAST  = (i == last_at - 1);
            if (toggle) begin
                if (gnt == 1) M1_RREADY = (cyc % 2 == 0); else M0_RREADY = (cyc % 2 == 0);
            end
            #1;
            grv  = (gnt == 1) ? M1_RVALID : M0_RVALID;
            grr  = (gnt == 1) ? M1_RREADY : M0_RREADY;
            grd  = (gnt == 1) ? M1_RDATA  : M0_RDATA;
            grl  = (gnt == 1) ? M1_RLAST  : M0_RLAST;
            ngrv = (gnt == 1) ? M0_RVALID : M1_RVALID;
            if (S_RREADY !== grr) bad++;
            if (ngrv !== 1'b0) bad++;
            if (grv !== 1'b1) bad++;
            if (grr) begin
                if (grd !== base + 64'(i) || grl !== S_RLAST) bad++;
                i++;
                beats++;
            end
            tick();
            cyc++;
        end
        S_RVALID = 1'b0;
        S_RLAST  = 1'b0;
        if (toggle) begin M0_RREADY = 1'b1; M1_RREADY = 1'b1; end
    endtask

    task automatic test_reset;
        ARST = 1'b1;
        M0_ARVALID = 1'b1; S_RVALID = 1'b1; S_ARREADY = 1'b1; M0_RREADY = 1'b1;
        tick(); tick(); tick();
        #1;
        n_chk++; if ({M0_ARREADY, M1_ARREADY, M0_RVALID, M1_RVALID, S_ARVALID, S_RREADY} !== 6'b0) begin
            n_fail++; $display("FAIL reset_handshakes: got %b want 000000",
                {M0_ARREADY, M1_ARREADY, M0_RVALID, M1_RVALID, S_ARVALID, S_RREADY}); end
        n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        n_chk++; if (LEN_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_lenerr: got %b want 0", LEN_ERR); end
        M0_ARVALID = 1'b0; S_RVALID = 1'b0; S_ARREADY = 1'b0;
        tick();
        ARST = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        int g, b, bad;
        logic [AW-1:0] a;
        M0_ARADDR = 32'h1000_0000; M0_ARLEN = 8'd15; M0_ARVALID = 1'b1; M1_RREADY = 1'b1;
        #1;
        n_chk++; if (S_ARVALID !== 1'b0) begin n_fail++; $display("FAIL basic_arvalid_lat0: got %b want 0", S_ARVALID); end
        tick(); #1;
        n_chk++; if (S_ARVALID !== 1'b1) begin n_fail++; $display("FAIL basic_arvalid_lat1: got %b want 1", S_ARVALID); end
        n_chk++; if (S_ARADDR !== 32'h1000_0000 || S_ARLEN !== 8'd15) begin
            n_fail++; $display("FAIL basic_ar_fields: got %h/%0d want 10000000/15", S_ARADDR, S_ARLEN); end
        n_chk++; if (M0_ARREADY !== 1'b0 || BUSY !== 1'b1) begin
            n_fail++; $display("FAIL basic_addr_state: got arready=%b busy=%b want 0/1", M0_ARREADY, BUSY); end
        serve(16, 64'hA000, 1'b0, 1'b0, g, a, b, bad);
        n_chk++; if (g !== 0) begin n_fail++; $display("FAIL basic_gnt: got %0d want 0", g); end
        n_chk++; if (b !== 16 || bad !== 0) begin n_fail++; $display("FAIL basic_beats: got %0d beats %0d errs want 16/0", b, bad); end
        #1;
        n_chk++; if (BUSY !== 1'b0 || LEN_ERR !== 1'b0) begin
            n_fail++; $display("FAIL basic_done: got busy=%b len_err=%b want 0/0", BUSY, LEN_ERR); end
    endtask

    task automatic test_round_robin;
        int g, b, bad;
        logic [AW-1:0] a;
        int exp_g[3];
`ifdef VRAM_RD_ARB_FIXPRI_EN
        exp_g = '{0, 0, 0};
`else
        exp_g = '{0, 1, 0};
`endif
        ARST = 1'b1; tick(); ARST = 1'b0;
        M0_ARADDR = 32'h2000_0000; M1_ARADDR = 32'h3000_0000;
        M0_ARLEN = 8'd15; M1_ARLEN = 8'd15;
        M0_ARVALID = 1'b1; M1_ARVALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            serve(16, 64'hB000 + 64'(k * 256), 1'b0, 1'b1, g, a, b, bad);
            n_chk++; if (g !== exp_g[k]) begin n_fail++; $display("FAIL rr_gnt%0d: got %0d want %0d", k, g, exp_g[k]); end
            n_chk++; if (a !== (exp_g[k] == 1 ? 32'h3000_0000 : 32'h2000_0000)) begin
                n_fail++; $display("FAIL rr_addr%0d: got %h want port%0d address", k, a, exp_g[k]); end
            n_chk++; if (b !== 16 || bad !== 0) begin
                n_fail++; $display("FAIL rr_beats%0d: got %0d beats %0d errs want 16/0", k, b, bad); end
        end
        M0_ARVALID = 1'b0; M1_ARVALID = 1'b0;
        tick();
    endtask

    task automatic test_ar_stall;
        int g, b, bad;
        logic [AW-1:0] a;
        S_ARREADY = 1'b0;
        M0_ARADDR = 32'h4000_0040; M0_ARLEN = 8'd15; M0_ARVALID = 1'b1;
        tick();
        M1_ARADDR = 32'h5000_0000; M1_ARLEN = 8'd3; M1_ARVALID = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_chk++; if ({S_ARVALID, M0_ARREADY, M1_ARREADY} !== 3'b100 || S_ARADDR !== 32'h4000_0040 || S_ARLEN !== 8'd15) begin
                n_fail++; $display("FAIL stall_c%0d: got v/r0/r1=%b addr=%h len=%0d want 100/40000040/15",
                    c, {S_ARVALID, M0_ARREADY, M1_ARREADY}, S_ARADDR, S_ARLEN); end
            tick();
        end
        serve(16, 64'hC000, 1'b0, 1'b0, g, a, b, bad);
        n_chk++; if (g !== 0 || b !== 16 || bad !== 0) begin
            n_fail++; $display("FAIL stall_m0: got gnt=%0d beats=%0d errs=%0d want 0/16/0", g, b, bad); end
        serve(4, 64'hC100, 1'b0, 1'b0, g, a, b, bad);
        n_chk++; if (g !== 1 || a !== 32'h5000_0000 || b !== 4 || bad !== 0) begin
            n_fail++; $display("FAIL stall_m1: got gnt=%0d addr=%h beats=%0d errs=%0d want 1/50000000/4/0", g, a, b, bad); end
    endtask

    task automatic test_rready_toggle;
        int g, b, bad;
        logic [AW-1:0] a;
        M0_ARADDR = 32'h6000_0000; M0_ARLEN = 8'd15; M0_ARVALID = 1'b1; M1_RREADY = 1'b1;
        serve(16, 64'hD000, 1'b1, 1'b0, g, a, b, bad);
        n_chk++; if (g !== 0 || b !== 16 || bad !== 0) begin
            n_fail++; $display("FAIL toggle: got gnt=%0d beats=%0d errs=%0d want 0/16/0", g, b, bad); end
    endtask

    task automatic test_long_burst;
        int g, b, bad;
        logic [AW-1:0] a;
        M1_ARADDR = 32'h7000_0000; M1_ARLEN = 8'd255; M1_ARVALID = 1'b1;
        serve(256, 64'hE000, 1'b0, 1'b0, g, a, b, bad);
        n_chk++; if (g !== 1 || b !== 256 || bad !== 0) begin
            n_fail++; $display("FAIL long_beats: got gnt=%0d beats=%0d errs=%0d want 1/256/0", g, b, bad); end
        #1;
        n_chk++; if (LEN_ERR !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++; $display("FAIL long_lenerr: got len_err=%b busy=%b want 0/0", LEN_ERR, BUSY); end
    endtask

    task automatic test_len_error;
        int g, b, bad;
        logic [AW-1:0] a;
        M0_ARADDR = 32'h1100_0000; M0_ARLEN = 8'd15; M0_ARVALID = 1'b1;
        serve(8, 64'hF000, 1'b0, 1'b0, g, a, b, bad);
        #1;
        n_chk++; if (b !== 8 || BUSY !== 1'b0) begin n_fail++; $display("FAIL short_idle: got beats=%0d busy=%b want 8/0", b, BUSY); end
        n_chk++; if (LEN_ERR !== 1'b1) begin n_fail++; $display("FAIL short_lenerr: got %b want 1", LEN_ERR); end
        M1_ARADDR = 32'h1200_0000; M1_ARLEN = 8'd3; M1_ARVALID = 1'b1;
        serve(4, 64'hF100, 1'b0, 1'b0, g, a, b, bad);
        #1;
        n_chk++; if (LEN_ERR !== 1'b1 || b !== 4) begin
            n_fail++; $display("FAIL sticky_lenerr: got len_err=%b beats=%0d want 1/4", LEN_ERR, b); end
    endtask

    task automatic test_reset_midburst;
        int g, b, bad;
        logic [AW-1:0] a;
        M0_ARADDR = 32'h8000_0000; M0_ARLEN = 8'd15; M0_ARVALID = 1'b1; S_ARREADY = 1'b1;
        tick(); tick();
        M0_ARVALID = 1'b0; S_ARREADY = 1'b0; S_RVALID = 1'b1; S_RLAST = 1'b0;
        for (int i = 0; i < 4; i++) begin S_RDATA = 64'(i); tick(); end
        #1;
        n_chk++; if (M0_RVALID !== 1'b1 || BUSY !== 1'b1) begin
            n_fail++; $display("FAIL mid_active: got rvalid=%b busy=%b want 1/1", M0_RVALID, BUSY); end
        ARST = 1'b1;
        tick(); #1;
        n_chk++; if ({S_ARVALID, S_RREADY, M0_RVALID, M1_RVALID, M0_ARREADY, M1_ARREADY} !== 6'b0) begin
            n_fail++; $display("FAIL mid_rst_handshakes: got %b want 000000",
                {S_ARVALID, S_RREADY, M0_RVALID, M1_RVALID, M0_ARREADY, M1_ARREADY}); end
        n_chk++; if (BUSY !== 1'b0 || LEN_ERR !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_state: got busy=%b len_err=%b want 0/0", BUSY, LEN_ERR); end
        ARST = 1'b0; S_RVALID = 1'b0;
        tick();
        M1_ARADDR = 32'h9000_0000; M1_ARLEN = 8'd3; M1_ARVALID = 1'b1;
        serve(4, 64'h9900, 1'b0, 1'b0, g, a, b, bad);
        #1;
        n_chk++; if (g !== 1 || a !== 32'h9000_0000 || b !== 4 || bad !== 0 || LEN_ERR !== 1'b0) begin
            n_fail++; $display("FAIL mid_after: got gnt=%0d addr=%h beats=%0d errs=%0d len_err=%b want 1/90000000/4/0/0",
                g, a, b, bad, LEN_ERR); end
    endtask

    initial begin
        ARST = 1'b1;
        M0_ARADDR = '0; M0_ARLEN = '0; M0_ARVALID = 1'b0; M0_RREADY = 1'b1;
        M1_ARADDR = '0; M1_ARLEN = '0; M1_ARVALID = 1'b0; M1_RREADY = 1'b1;
        S_ARREADY = 1'b0; S_RDATA = '0; S_RLAST = 1'b0; S_RVALID = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_ar_stall();
        test_rready_toggle();
        test_long_burst();
        test_len_error();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
